mem_port_arbiter: RTL

- Shares one single-port synchronous memory (BIOS/IMEM-style, 1-cycle read latency) between the CPU instruction-fetch port (I) and the data load/store port (D).
- Arbitrates each cycle and drives the memory port.
- Routes read data back with a per-port valid.
- Keeps a saturating conflict counter for CSR/debug readout.
- Sits between the cpu pipeline's fetch/memory stages and the memory instance.

---
 rtl/mem_port_arbiter_if.sv | 30 +++
 rtl/mem_port_arbiter.sv | 45 ++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/load-store requester ports and shared memory port bundle
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  logic              i_req;
  logic [AWIDTH-1:0] i_addr;
  logic              i_ack;
  logic              i_rvalid;
  logic              d_req;
  logic [DWIDTH/8-1:0] d_we;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic              d_ack;
  logic              d_rvalid;
  logic [DWIDTH-1:0] rdata;
  logic              mem_en;
  logic [DWIDTH/8-1:0] mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_din;
  logic [DWIDTH-1:0] mem_dout;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    input  i_ack, i_rvalid, d_ack, d_rvalid, rdata, mem_en, mem_we, mem_addr, mem_din
  );
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
    output i_ack, i_rvalid, d_ack, d_rvalid, rdata, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency memory between fetch (I) and load/store (D) ports
module mem_port_arbiter #(
  parameter int AWIDTH       = 12,
  parameter int DWIDTH       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  mem_port_arbiter_if.slave bus,
  input  logic        clr_cnt,
  output logic [31:0] conflict_cnt
);
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;
  owner_t      owner;
  logic [3:0]  starve_cnt;
  logic [31:0] cnt_q;
  logic        i_win;
  logic        both;
  // D normally wins a conflict; I takes over once it has been starved long enough
  assign both   = bus.i_req & bus.d_req;
  assign i_win  = bus.i_req & (~bus.d_req | (starve_cnt >= 4'(STARVE_LIMIT)));
  assign bus.i_ack = rst & i_win;
  assign bus.d_ack = rst & bus.d_req & ~i_win;
  assign bus.i_rvalid = owner == OWN_I;
  assign bus.d_rvalid = owner == OWN_D;
  assign bus.rdata    = bus.mem_dout;
  assign conflict_cnt = cnt_q;
  always_comb begin
    bus.mem_en   = bus.i_ack | bus.d_ack;
    bus.mem_we   = bus.d_ack ? bus.d_we : '0;
    bus.mem_din  = bus.d_ack ? bus.d_wdata : '0;
    bus.mem_addr = bus.d_ack ? bus.d_addr : bus.i_ack ? bus.i_addr : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      cnt_q      <= '0;
    end else begin
      owner      <= bus.i_ack ? OWN_I : (bus.d_ack && bus.d_we == '0) ? OWN_D : OWN_NONE;
      starve_cnt <= (!bus.i_req || bus.i_ack) ? 4'd0 : (starve_cnt == 4'hF) ? starve_cnt : starve_cnt + 4'd1;
      cnt_q      <= clr_cnt ? 32'd0 : (both && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    end
  end
endmodule
